// File: rtl/vga_serial_pkg.sv
// ----------------------------------------------------------------------------
// vga_serial_pkg
// Constants and types shared by the VGA serial display blocks: the frame-RAM
// serial reader and the UART RAM writer.
//   H_RES, V_RES, BPP : default frame geometry (1024x768, 24 bits per pixel)
//   FRAME_BITS        : bits in one full frame
//   wr_state_e        : writer FSM state encoding (IDLE, RECEIVE, WRITE)
//   frame_words()     : number of RAM words per frame for a given word width
// ----------------------------------------------------------------------------
package vga_serial_pkg;

  localparam int unsigned H_RES      = 1024;
  localparam int unsigned V_RES      = 768;
  localparam int unsigned BPP        = 24;
  localparam int unsigned FRAME_BITS = H_RES * V_RES * BPP;

  // Encodings kept as plain constants so older code can compare raw bits.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RECEIVE = ST_RECEIVE,
    WRITE   = ST_WRITE
  } wr_state_e;

  // Words needed to hold one frame when each RAM word is `width` bits.
  function automatic int unsigned frame_words(input int unsigned width);
    return FRAME_BITS / width;
  endfunction

endpackage

// File: rtl/uart_ram_writer_byte_packer.sv
// ----------------------------------------------------------------------------
// byte_packer
// Collects bytes into a RAM_WIDTH-bit word, first byte in the top byte lane
// (big-endian), last byte in [7:0].
//   clk, rst          : clock, synchronous active-high reset
//   clear_i           : drop the partial word and restart at byte 0
//   byte_valid_i      : byte_i is accepted this cycle
//   byte_i            : incoming byte
//   word_o            : the word including byte_i (meaningful on completion)
//   word_complete_o   : byte_i is the last byte of the word
// ----------------------------------------------------------------------------
module byte_packer #(
  parameter int unsigned RAM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic [RAM_WIDTH-1:0] word_o,
  output logic                 word_complete_o
);

  localparam int unsigned BYTES_PER_WORD = RAM_WIDTH / 8;
  localparam int unsigned IDX_BITS = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(BYTES_PER_WORD - 1);

  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                last_byte_s;

  assign last_byte_s     = (idx_q == LAST_IDX);
  assign word_complete_o = byte_valid_i && last_byte_s;

  // Byte index: advances per accepted byte, wraps after the last lane.
  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (byte_valid_i) begin
      idx_d = last_byte_s ? '0 : idx_q + IDX_BITS'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Byte index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  generate
    if (BYTES_PER_WORD == 1) begin : g_single
      assign word_o = byte_i;
    end else begin : g_multi
      // Only the lower RAM_WIDTH-8 bits need storing: the top lane of the
      // previous shift is always pushed out by the next byte.
      logic [RAM_WIDTH-9:0] part_q;

      assign word_o = {part_q, byte_i};

      // Partial-word shift register.
      always_ff @(posedge clk) begin
        if (rst || clear_i) begin
          part_q <= '0;
        end else if (byte_valid_i) begin
          part_q <= word_o[RAM_WIDTH-9:0];
        end else begin
          part_q <= part_q;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/uart_ram_writer.sv
// ----------------------------------------------------------------------------
// uart_ram_writer
// Packs bytes from the UART receiver into RAM words and writes them to the
// frame RAM from address 0 upward, flagging each completed frame. If the host
// goes quiet mid-frame for IDLE_TIMEOUT cycles the writer drops the partial
// word and restarts at address 0.
//   clk, rst    : clock, synchronous active-high reset
//   rx_data     : received byte, valid while rx_ready is high
//   rx_ready    : one-cycle byte strobe, may be back-to-back
//   wr_addr     : RAM write address (tracks the current word address)
//   wr_data     : RAM write data, held between writes
//   wr_en       : one-cycle write strobe
//   frame_done  : pulses with the write to address RAM_DEPTH-1
//   resync      : pulses when the idle timeout fires
//   busy        : a frame is partially received
// IDLE_TIMEOUT must be at least 2.
// ----------------------------------------------------------------------------
module uart_ram_writer
  import vga_serial_pkg::*;
#(
  parameter int unsigned RAM_WIDTH    = 8,
  parameter int unsigned RAM_DEPTH    = (H_RES * V_RES * BPP) / RAM_WIDTH,
  parameter int unsigned IDLE_TIMEOUT = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_ready,
  output logic [$clog2(RAM_DEPTH)-1:0] wr_addr,
  output logic [RAM_WIDTH-1:0]         wr_data,
  output logic                         wr_en,
  output logic                         frame_done,
  output logic                         resync,
  output logic                         busy
);

  localparam int unsigned ADDR_BITS = $clog2(RAM_DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(RAM_DEPTH - 1);
  // The timeout is decided one count early so that the registered resync
  // pulse lands exactly IDLE_TIMEOUT cycles after the last byte.
  localparam logic [31:0] TIMER_LAST = 32'(IDLE_TIMEOUT - 2);

  wr_state_e             state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [31:0]           timer_q, timer_d;
  logic [RAM_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  frame_done_q, frame_done_d;
  logic                  resync_q, resync_d;
  logic                  busy_q, busy_d;

  logic                  pk_clear_s;
  logic                  pk_complete_s;
  logic [RAM_WIDTH-1:0]  pk_word_s;

  byte_packer #(
    .RAM_WIDTH (RAM_WIDTH)
  ) u_packer (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (pk_clear_s),
    .byte_valid_i    (rx_ready),
    .byte_i          (rx_data),
    .word_o          (pk_word_s),
    .word_complete_o (pk_complete_s)
  );

  // FSM, address counter and idle timer next-state logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    timer_d    = timer_q;
    resync_d   = 1'b0;
    pk_clear_s = 1'b0;

    case (state_q)
      IDLE: begin
        addr_d  = '0;
        timer_d = '0;
        if (rx_ready) begin
          state_d = pk_complete_s ? WRITE : RECEIVE;
        end else begin
          state_d = IDLE;
        end
      end

      RECEIVE: begin
        if (rx_ready) begin
          // A byte on the limit cycle wins over the timeout.
          timer_d = '0;
          state_d = pk_complete_s ? WRITE : RECEIVE;
        end else if (timer_q >= TIMER_LAST) begin
          addr_d     = '0;
          timer_d    = '0;
          resync_d   = 1'b1;
          pk_clear_s = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
          state_d = RECEIVE;
        end
      end

      WRITE: begin
        addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_BITS'(1);
        if (rx_ready) begin
          // Byte 0 of the next word; continue even across a frame wrap.
          timer_d = '0;
          state_d = pk_complete_s ? WRITE : RECEIVE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          state_d = RECEIVE;
        end
      end

      default: begin
        state_d    = IDLE;
        addr_d     = '0;
        timer_d    = '0;
        pk_clear_s = 1'b1;
      end
    endcase
  end

  // Registered output next values, derived from where the FSM is heading.
  always_comb begin
    wr_en_d      = (state_d == WRITE);
    frame_done_d = (state_d == WRITE) && (addr_d == LAST_ADDR);
    busy_d       = (state_d != IDLE);
    if (rx_ready && pk_complete_s) begin
      wr_data_d = pk_word_s;
    end else begin
      wr_data_d = wr_data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      timer_q      <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      resync_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      timer_q      <= timer_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      resync_q     <= resync_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_addr    = addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign frame_done = frame_done_q;
  assign resync     = resync_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_ram_writer.sv
// ----------------------------------------------------------------------------
// tb_uart_ram_writer
// Two writers: "a" with 16-bit words and "b" with 8-bit words, both with
// 4 words per frame and a 20-cycle idle timeout. Expected RAM writes are
// queued as bytes are driven and compared against the writes a monitor
// collects from each instance.
// ----------------------------------------------------------------------------
module tb_uart_ram_writer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 20;

  typedef struct packed {
    logic        fd;
    logic [1:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  rx_data_a = 8'h00;
  logic        rx_ready_a = 1'b0;
  logic [1:0]  wr_addr_a;
  logic [15:0] wr_data_a;
  logic        wr_en_a, frame_done_a, resync_a, busy_a;

  logic [7:0]  rx_data_b = 8'h00;
  logic        rx_ready_b = 1'b0;
  logic [1:0]  wr_addr_b;
  logic [7:0]  wr_data_b;
  logic        wr_en_b, frame_done_b, resync_b, busy_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_cyc = 0;
  int fd_cnt_a = 0, fd_cnt_b = 0, resync_cnt_a = 0, resync_cyc_a = 0;

  wr_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];

  uart_ram_writer #(.RAM_WIDTH(16), .RAM_DEPTH(DEPTH), .IDLE_TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data_a), .rx_ready(rx_ready_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_en(wr_en_a),
    .frame_done(frame_done_a), .resync(resync_a), .busy(busy_a)
  );

  uart_ram_writer #(.RAM_WIDTH(8), .RAM_DEPTH(DEPTH), .IDLE_TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data_b), .rx_ready(rx_ready_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_en(wr_en_b),
    .frame_done(frame_done_b), .resync(resync_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record writes and pulses mid-cycle.
  always @(negedge clk) begin
    if (wr_en_a) obs_a.push_back({frame_done_a, wr_addr_a, wr_data_a});
    if (wr_en_b) obs_b.push_back({frame_done_b, wr_addr_b, 8'h00, wr_data_b});
    if (frame_done_a) fd_cnt_a++;
    if (frame_done_b) fd_cnt_b++;
    if (resync_a) begin
      resync_cnt_a++;
      resync_cyc_a = cyc;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    rx_data_a  = b;
    rx_ready_a = 1'b1;
    last_cyc   = cyc;
    @(posedge clk);
    #1;
    rx_ready_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    rx_data_b  = b;
    rx_ready_b = 1'b1;
    @(posedge clk);
    #1;
    rx_ready_b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    exp_a.delete(); obs_a.delete(); exp_b.delete(); obs_b.delete();
    fd_cnt_a = 0; fd_cnt_b = 0; resync_cnt_a = 0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    idle(3);
    got = {wr_en_a, frame_done_a, resync_a, busy_a, wr_en_b, busy_b, resync_b};
    total++;
    if (got !== 7'd0) begin
      bad++; $display("FAIL reset_flags got=%b want=0000000", got);
    end
    total++;
    if (wr_addr_a !== 2'd0 || wr_addr_b !== 2'd0) begin
      bad++; $display("FAIL reset_addr got=%0d/%0d want=0/0", wr_addr_a, wr_addr_b);
    end
    total++;
    if (wr_data_a !== 16'h0000 || wr_data_b !== 8'h00) begin
      bad++; $display("FAIL reset_data got=%h/%h want=0000/00", wr_data_a, wr_data_b);
    end
    rst = 1'b0;
    idle(1);
    exp_a.delete(); obs_a.delete(); exp_b.delete(); obs_b.delete();
  endtask

  task automatic test_packing();
    wr_t e, o;
    do_reset();
    send_a(8'hAB);
    idle(4);
    send_a(8'hCD);
    exp_a.push_back({1'b0, 2'd0, 16'hABCD});
    idle(3);
    total++;
    if (busy_a !== 1'b1) begin
      bad++; $display("FAIL pack_busy got=%b want=1", busy_a);
    end
    total++;
    if (wr_data_a !== 16'hABCD || wr_addr_a !== 2'd1) begin
      bad++; $display("FAIL pack_hold got=%h@%0d want=abcd@1", wr_data_a, wr_addr_a);
    end
    total++;
    if (obs_a.size() !== exp_a.size()) begin
      bad++; $display("FAIL pack_count got=%0d want=%0d", obs_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL pack_write got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_frame_wrap();
    wr_t e, o;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      send_a(8'(i));
      if (i % 2 == 0)
        exp_a.push_back({(i == 8), 2'(i / 2 - 1), 8'(i - 1), 8'(i)});
    end
    idle(3);
    total++;
    if (wr_addr_a !== 2'd0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL wrap_end got=addr%0d busy%b want=addr0 busy0", wr_addr_a, busy_a);
    end
    total++;
    if (fd_cnt_a !== 1) begin
      bad++; $display("FAIL wrap_fd_count got=%0d want=1", fd_cnt_a);
    end
    total++;
    if (obs_a.size() !== exp_a.size()) begin
      bad++; $display("FAIL wrap_count got=%0d want=%0d", obs_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL wrap_write got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    wr_t e, o;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_b(8'(8'h10 + i));
      exp_b.push_back({(i == 3), 2'(i % 4), 8'h00, 8'(8'h10 + i)});
    end
    idle(3);
    total++;
    if (fd_cnt_b !== 1) begin
      bad++; $display("FAIL b2b_fd_count got=%0d want=1", fd_cnt_b);
    end
    total++;
    if (wr_addr_b !== 2'd2 || busy_b !== 1'b1) begin
      bad++; $display("FAIL b2b_end got=addr%0d busy%b want=addr2 busy1", wr_addr_b, busy_b);
    end
    total++;
    if (obs_b.size() !== exp_b.size()) begin
      bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_b.size(), exp_b.size());
    end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front(); o = obs_b.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL b2b_write got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_idle_timeout();
    wr_t e, o;
    int  t_last;
    do_reset();
    send_a(8'h01);
    send_a(8'h02);
    exp_a.push_back({1'b0, 2'd0, 16'h0102});
    send_a(8'h03);
    t_last = last_cyc;
    idle(TO + 2);
    total++;
    if (resync_cnt_a !== 1) begin
      bad++; $display("FAIL to_resync_count got=%0d want=1", resync_cnt_a);
    end
    total++;
    if (resync_cyc_a - t_last !== TO) begin
      bad++; $display("FAIL to_resync_delay got=%0d want=%0d", resync_cyc_a - t_last, TO);
    end
    total++;
    if (wr_addr_a !== 2'd0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL to_state got=addr%0d busy%b want=addr0 busy0", wr_addr_a, busy_a);
    end
    send_a(8'h11);
    send_a(8'h22);
    exp_a.push_back({1'b0, 2'd0, 16'h1122});
    idle(3);
    total++;
    if (obs_a.size() !== exp_a.size()) begin
      bad++; $display("FAIL to_count got=%0d want=%0d", obs_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL to_write got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_race_and_reset();
    wr_t e, o;
    do_reset();
    // Second byte lands on the cycle the timeout would otherwise fire.
    send_a(8'hA5);
    idle(TO - 2);
    send_a(8'h5A);
    exp_a.push_back({1'b0, 2'd0, 16'hA55A});
    idle(5);
    total++;
    if (resync_cnt_a !== 0) begin
      bad++; $display("FAIL race_resync got=%0d want=0", resync_cnt_a);
    end
    total++;
    if (obs_a.size() !== exp_a.size()) begin
      bad++; $display("FAIL race_count got=%0d want=%0d", obs_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL race_write got=%h want=%h", o, e);
      end
    end
    // Reset mid-word, with the completing byte arriving on the reset edge.
    do_reset();
    send_a(8'h77);
    rx_data_a  = 8'h88;
    rx_ready_a = 1'b1;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    rx_ready_a = 1'b0;
    rst        = 1'b0;
    idle(3);
    total++;
    if (obs_a.size() !== 0 || wr_addr_a !== 2'd0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL rst_mid got=writes%0d addr%0d busy%b want=writes0 addr0 busy0",
                      obs_a.size(), wr_addr_a, busy_a);
    end
    send_a(8'hC1);
    send_a(8'hC2);
    exp_a.push_back({1'b0, 2'd0, 16'hC1C2});
    idle(3);
    total++;
    if (obs_a.size() !== exp_a.size()) begin
      bad++; $display("FAIL rst_after_count got=%0d want=%0d", obs_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); total++;
      if (o !== e) begin
        bad++; $display("FAIL rst_after_write got=%h want=%h", o, e);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_packing();
    test_frame_wrap();
    test_back_to_back();
    test_idle_timeout();
    test_race_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
